// File: rtl/song_writer_pkg.sv
// Shared definitions for the song writer and song player: opcodes, limits,
// FSM encoding and small symbol helpers.
package song_writer_pkg;

  localparam logic [3:0] OP_REST        = 4'hE;
  localparam logic [3:0] OP_OCT_PREFIX  = 4'hC;
  localparam logic [3:0] OP_REPEAT      = 4'hD;
  localparam logic [2:0] OCT_MAX        = 3'd4;
  localparam logic [3:0] NOTE_COUNT     = 4'd12;
  localparam logic [8:0] END_ADDR_LIMIT = 9'd254;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REC,
    ST_EMIT_C,
    ST_EMIT_OCT,
    ST_EMIT_NOTE,
    ST_END0,
    ST_END1,
    ST_DONE
  } state_t;

  // Held key becomes its note index; no key or an out-of-range note is a rest.
  function automatic logic [3:0] encode_symbol(input logic valid, input logic [3:0] note);
    return (valid && (note < NOTE_COUNT)) ? note : OP_REST;
  endfunction

  function automatic logic [2:0] clamp_octave(input logic [2:0] oct);
    return (oct > OCT_MAX) ? OCT_MAX : oct;
  endfunction

endpackage

// File: rtl/song_writer_tempo_tick.sv
// Level-selected tempo tick: free-running counter 0..compare, one-cycle tick
// at the top. Shared with the song player.
module tempo_tick #(
  parameter int CNT_W = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic [3:0] level,
  output logic       tick
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] compare;

  assign compare = {CNT_W{1'b1}} - {1'b0, level, {(CNT_W-5){1'b1}}};
  assign tick    = (count == compare);

  // Count up to compare, then wrap; clear realigns the phase to a new song.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/song_writer.sv
// Records live key input into run-length encoded song bytes for the player.
//
// state        | meaning
// IDLE         | waiting for start
// REC          | sampling keys on tick, tracking the open run
// EMIT_C       | writing octave-prefix opcode 0xC0
// EMIT_OCT     | writing the octave byte
// EMIT_NOTE    | writing {symbol, len-1}
// END0         | writing end opcode 0xD0
// END1         | writing loop target 0x00
// DONE         | song complete, waiting for a new start
module song_writer
  import song_writer_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] level,
  input  logic       start,
  input  logic       stop,
  input  logic       key_valid,
  input  logic [3:0] key_note,
  input  logic [2:0] key_octave,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       recording,
  output logic       done,
  output logic       full
);

  state_t     state, state_n;
  logic       tick, start_ok;

  logic       run_open, run_open_n;
  logic [3:0] run_cnt, run_cnt_n;
  logic [3:0] run_sym, run_sym_n;
  logic [2:0] run_oct, run_oct_n;

  logic [3:0] em_sym, em_sym_n;
  logic [3:0] em_cnt, em_cnt_n;
  logic [2:0] em_oct, em_oct_n;

  logic [2:0] last_oct, last_oct_n;
  logic       last_oct_ok, last_oct_ok_n;
  logic       stop_pend, stop_pend_n;

  logic       wr_en_n;
  logic [7:0] wr_addr_n, wr_data_n;
  logic       recording_n, done_n, full_n;

  logic [3:0] samp_sym;
  logic [2:0] samp_oct;
  logic       emit_req, need_prefix;
  logic [3:0] cand_sym, cand_cnt;
  logic [2:0] cand_oct;
  logic [8:0] free_addr, bytes_needed;

  assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign samp_sym  = encode_symbol(key_valid, key_note);
  assign samp_oct  = clamp_octave(key_octave);
  // wr_addr advances the cycle after a write, so a write in flight still owns it.
  assign free_addr = {1'b0, wr_addr} + {8'd0, wr_en};

  tempo_tick #(.CNT_W(CNT_W)) u_tempo_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (start_ok),
    .level (level),
    .tick  (tick)
  );

  // Next-state, run tracking and registered-output values.
  always_comb begin
    state_n       = state;
    run_open_n    = run_open;
    run_cnt_n     = run_cnt;
    run_sym_n     = run_sym;
    run_oct_n     = run_oct;
    em_sym_n      = em_sym;
    em_cnt_n      = em_cnt;
    em_oct_n      = em_oct;
    last_oct_n    = last_oct;
    last_oct_ok_n = last_oct_ok;
    stop_pend_n   = stop_pend;
    wr_en_n       = 1'b0;
    wr_addr_n     = wr_en ? (wr_addr + 8'd1) : wr_addr;
    wr_data_n     = wr_data;
    recording_n   = recording;
    done_n        = done;
    full_n        = full;
    emit_req      = 1'b0;
    cand_sym      = run_sym;
    cand_cnt      = run_cnt;
    cand_oct      = run_oct;
    need_prefix   = 1'b0;
    bytes_needed  = 9'd1;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_n       = ST_REC;
          run_open_n    = 1'b0;
          run_cnt_n     = 4'd0;
          last_oct_ok_n = 1'b0;
          stop_pend_n   = 1'b0;
          wr_addr_n     = 8'd0;
          recording_n   = 1'b1;
          done_n        = 1'b0;
          full_n        = 1'b0;
        end
      end
      ST_REC: begin
        stop_pend_n = stop_pend | stop;
        if (tick) begin
          if (run_open && (samp_sym == run_sym) && (samp_oct == run_oct) && (run_cnt != 4'hF)) begin
            run_cnt_n = run_cnt + 4'd1;
          end else begin
            emit_req   = run_open;
            run_open_n = 1'b1;
            run_cnt_n  = 4'd0;
            run_sym_n  = samp_sym;
            run_oct_n  = samp_oct;
          end
        end else if (stop_pend) begin
          if (run_open) begin
            emit_req   = 1'b1;
            run_open_n = 1'b0;
            run_cnt_n  = 4'd0;
          end else begin
            state_n = ST_END0;
          end
        end
      end
      ST_EMIT_C: begin
        stop_pend_n = stop_pend | stop;
        wr_en_n     = 1'b1;
        wr_data_n   = {OP_OCT_PREFIX, 4'h0};
        state_n     = ST_EMIT_OCT;
      end
      ST_EMIT_OCT: begin
        stop_pend_n   = stop_pend | stop;
        wr_en_n       = 1'b1;
        wr_data_n     = {1'b0, em_oct, 4'h0};
        last_oct_n    = em_oct;
        last_oct_ok_n = 1'b1;
        state_n       = ST_EMIT_NOTE;
      end
      ST_EMIT_NOTE: begin
        stop_pend_n = stop_pend | stop;
        wr_en_n     = 1'b1;
        wr_data_n   = {em_sym, em_cnt};
        state_n     = ST_REC;
      end
      ST_END0: begin
        wr_en_n   = 1'b1;
        wr_data_n = {OP_REPEAT, 4'h0};
        state_n   = ST_END1;
      end
      ST_END1: begin
        wr_en_n     = 1'b1;
        wr_data_n   = 8'h00;
        recording_n = 1'b0;
        done_n      = 1'b1;
        state_n     = ST_DONE;
      end
      default: state_n = ST_IDLE;
    endcase

    // A closing run is written only if it fits below the reserved end marker.
    if (emit_req) begin
      need_prefix  = (cand_sym != OP_REST) && (!last_oct_ok || (cand_oct != last_oct));
      bytes_needed = need_prefix ? 9'd3 : 9'd1;
      if ((free_addr + bytes_needed) > END_ADDR_LIMIT) begin
        full_n  = 1'b1;
        state_n = ST_END0;
      end else begin
        em_sym_n = cand_sym;
        em_cnt_n = cand_cnt;
        em_oct_n = cand_oct;
        state_n  = need_prefix ? ST_EMIT_C : ST_EMIT_NOTE;
      end
    end
  end

  // State, run tracking and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      run_open    <= 1'b0;
      run_cnt     <= 4'd0;
      run_sym     <= 4'd0;
      run_oct     <= 3'd0;
      em_sym      <= 4'd0;
      em_cnt      <= 4'd0;
      em_oct      <= 3'd0;
      last_oct    <= 3'd0;
      last_oct_ok <= 1'b0;
      stop_pend   <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= 8'd0;
      wr_data     <= 8'd0;
      recording   <= 1'b0;
      done        <= 1'b0;
      full        <= 1'b0;
    end else begin
      state       <= state_n;
      run_open    <= run_open_n;
      run_cnt     <= run_cnt_n;
      run_sym     <= run_sym_n;
      run_oct     <= run_oct_n;
      em_sym      <= em_sym_n;
      em_cnt      <= em_cnt_n;
      em_oct      <= em_oct_n;
      last_oct    <= last_oct_n;
      last_oct_ok <= last_oct_ok_n;
      stop_pend   <= stop_pend_n;
      wr_en       <= wr_en_n;
      wr_addr     <= wr_addr_n;
      wr_data     <= wr_data_n;
      recording   <= recording_n;
      done        <= done_n;
      full        <= full_n;
    end
  end

endmodule
